// File: rtl/imuldiv_div_issuer_if.sv
// imuldiv_div_issuer_if: request, divider and response channels of the divide issuer.
interface imuldiv_div_issuer_if #(parameter int TAG_W = 5);
  logic             req_val;
  logic             req_rdy;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             divreq_msg_fn;
  logic [31:0]      divreq_msg_a;
  logic [31:0]      divreq_msg_b;
  logic             divreq_val;
  logic             divreq_rdy;
  logic [63:0]      divresp_msg_result;
  logic             divresp_val;
  logic             divresp_rdy;
  logic             resp_val;
  logic             resp_rdy;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [15:0]      done_count;
  modport master (
    input  req_val, req_op, req_a, req_b, req_tag, divreq_rdy, divresp_msg_result, divresp_val, resp_rdy,
    output req_rdy, divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy, resp_val, resp_data,
           resp_tag, done_count
  );
  modport slave (
    output req_val, req_op, req_a, req_b, req_tag, divreq_rdy, divresp_msg_result, divresp_val, resp_rdy,
    input  req_rdy, divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy, resp_val, resp_data,
           resp_tag, done_count
  );
endinterface

// File: rtl/imuldiv_div_issuer.sv
// imuldiv_div_issuer: queues tagged div/rem ops and issues them one at a time to the divider.
// Optional IMULDIV_DIVZERO_BYPASS_EN answers divide-by-zero locally without using the divider.
module imuldiv_div_issuer #(
  parameter int TAG_W       = 5,
  parameter int QUEUE_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  imuldiv_div_issuer_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [1:0]       op_q  [QUEUE_DEPTH];
  logic [31:0]      a_q   [QUEUE_DEPTH];
  logic [31:0]      b_q   [QUEUE_DEPTH];
  logic [TAG_W-1:0] tag_q [QUEUE_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, empty, zb, sel_rem;
  logic [TAG_W-1:0] tag_l, resp_tag_q;
  logic [31:0]      resp_data_q;
  logic [15:0]      done_q;
  assign empty              = count == '0;
  assign bus.req_rdy        = count != CW'(QUEUE_DEPTH);
  assign push               = bus.req_val && bus.req_rdy;
  assign bus.divreq_msg_fn  = op_q[rd_ptr][0];
  assign bus.divreq_msg_a   = a_q[rd_ptr];
  assign bus.divreq_msg_b   = b_q[rd_ptr];
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_tag       = resp_tag_q;
  assign bus.done_count     = done_q;
`ifdef IMULDIV_DIVZERO_BYPASS_EN
  assign zb = b_q[rd_ptr] == '0;
`else
  assign zb = 1'b0;
`endif
  always_comb begin
    state_n         = state;
    pop             = 1'b0;
    bus.divreq_val  = 1'b0;
    bus.divresp_rdy = state == WAIT;
    bus.resp_val    = state == RESP;
    if (state == ISSUE) begin
      bus.divreq_val = !empty && !zb;
      pop            = !empty && (zb || bus.divreq_rdy);
      state_n        = !pop ? ISSUE : zb ? RESP : WAIT;
    end else if (state == WAIT) begin
      state_n = bus.divresp_val ? RESP : WAIT;
    end else begin
      state_n = bus.resp_rdy ? ISSUE : RESP;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[wr_ptr]  <= bus.req_op;
      a_q[wr_ptr]   <= bus.req_a;
      b_q[wr_ptr]   <= bus.req_b;
      tag_q[wr_ptr] <= bus.req_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ISSUE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sel_rem     <= 1'b0;
      tag_l       <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
      done_q      <= '0;
    end else begin
      state <= state_n;
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        sel_rem <= op_q[rd_ptr][1];
        tag_l   <= tag_q[rd_ptr];
      end
      // a bypassed divide-by-zero lands in RESP directly, so its result is formed at pop time
      if (pop && zb) begin
        resp_data_q <= op_q[rd_ptr][1] ? a_q[rd_ptr] : '1;
        resp_tag_q  <= tag_q[rd_ptr];
      end
      if (state == WAIT && bus.divresp_val) begin
        resp_data_q <= sel_rem ? bus.divresp_msg_result[63:32] : bus.divresp_msg_result[31:0];
        resp_tag_q  <= tag_l;
      end
      if (bus.resp_val && bus.resp_rdy) done_q <= done_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_imuldiv_div_issuer.sv
// tb_imuldiv_div_issuer: table vectors, directed corner cases and random traffic against a divider model.
module tb_imuldiv_div_issuer;
  logic clk = 1'b0;
  logic reset;
  int total = 0, bad = 0, issues = 0, done_m = 0, wcnt = 0, lat = 0;
  logic busy = 1'b0;
  logic [63:0] dres;
  typedef struct packed {logic [4:0] tag; logic [31:0] data;} exp_t;
  exp_t sb[$];
  typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] tag; logic [31:0] exp;} vec_t;
  vec_t tv[8];
  imuldiv_div_issuer_if #(.TAG_W(5)) bus();
  imuldiv_div_issuer #(.TAG_W(5), .QUEUE_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa = a;
    sbv = b;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    if (s) return {32'(sa % sbv), 32'(sa / sbv)};
    return {a % b, a / b};
  endfunction
  function automatic logic [31:0] pick(input logic [63:0] r, input logic rem);
    return rem ? r[63:32] : r[31:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic rf, isf, drf, rsf, ifn;
    logic [31:0] ia, ib, rd;
    logic [4:0] rt;
    exp_t e;
    rf  = bus.req_val && bus.req_rdy;
    isf = bus.divreq_val && bus.divreq_rdy;
    drf = bus.divresp_val && bus.divresp_rdy;
    rsf = bus.resp_val && bus.resp_rdy;
    ifn = bus.divreq_msg_fn;
    ia  = bus.divreq_msg_a;
    ib  = bus.divreq_msg_b;
    rd  = bus.resp_data;
    rt  = bus.resp_tag;
    e   = {bus.req_tag, pick(ref_div(bus.req_op[0], bus.req_a, bus.req_b), bus.req_op[1])};
    @(posedge clk);
    @(negedge clk);
    if (reset) begin
      sb.delete();
      busy = 1'b0;
      bus.divresp_val = 1'b0;
      done_m = 0;
    end else begin
      if (rf) sb.push_back(e);
      if (rsf) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_extra tag=%h data=%h", rt, rd);
        end else begin
          e = sb.pop_front();
          chk("sb_tag", 64'(rt), 64'(e.tag));
          chk("sb_data", 64'(rd), 64'(e.data));
          done_m++;
        end
      end
      if (drf) begin
        bus.divresp_val = 1'b0;
        busy = 1'b0;
      end
      if (isf) begin
        issues++;
`ifdef IMULDIV_DIVZERO_BYPASS_EN
        if (ib == 0) chk("bypass_issued_b", 64'(ib), 64'd1);
`endif
        dres = ref_div(ifn, ia, ib);
        busy = 1'b1;
        wcnt = lat;
      end
      if (busy && !bus.divresp_val) begin
        if (wcnt == 0) begin
          bus.divresp_val = 1'b1;
          bus.divresp_msg_result = dres;
        end else wcnt--;
      end
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_tag = tag;
    bus.req_val = 1'b1;
    for (int i = 0; i < 50 && !bus.req_rdy; i++) tick();
    chk("send_rdy", 64'(bus.req_rdy), 64'd1);
    tick();
    bus.req_val = 1'b0;
  endtask
  task automatic wait_resp();
    for (int i = 0; i < 100 && !bus.resp_val; i++) tick();
    chk("resp_timeout", 64'(bus.resp_val), 64'd1);
  endtask
  initial begin
    reset = 1'b1;
    bus.req_val = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.divreq_rdy = 1'b1;
    bus.divresp_val = 1'b0;
    bus.divresp_msg_result = '0;
    bus.resp_rdy = 1'b0;
    tick();
    tick();
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
    chk("rst_divreq_val", 64'(bus.divreq_val), 64'd0);
    chk("rst_divresp_rdy", 64'(bus.divresp_rdy), 64'd0);
    chk("rst_resp_val", 64'(bus.resp_val), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
    chk("rst_done", 64'(bus.done_count), 64'd0);
    reset = 1'b0;
    tv[0] = '{2'd0, 32'd100, 32'd7, 5'd3, 32'd14};
    tv[1] = '{2'd2, 32'd100, 32'd7, 5'd4, 32'd2};
    tv[2] = '{2'd1, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD};
    tv[3] = '{2'd3, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF};
    tv[4] = '{2'd0, 32'd5, 32'd0, 5'd7, 32'hFFFFFFFF};
    tv[5] = '{2'd2, 32'd5, 32'd0, 5'd8, 32'd5};
    tv[6] = '{2'd1, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000};
    tv[7] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'd0};
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      send(tv[i].op, tv[i].a, tv[i].b, tv[i].tag);
      wait_resp();
      chk("vec_data", 64'(bus.resp_data), 64'(tv[i].exp));
      chk("vec_tag", 64'(bus.resp_tag), 64'(tv[i].tag));
      bus.resp_rdy = 1'b1;
      tick();
      bus.resp_rdy = 1'b0;
      chk("vec_done", 64'(bus.done_count), 64'(i + 1));
    end
    send(2'd0, 32'd5, 32'd0, 5'd15);
    chk("dz_resp_early", 64'(bus.resp_val), 64'd0);
`ifdef IMULDIV_DIVZERO_BYPASS_EN
    chk("dz_no_divreq", 64'(bus.divreq_val), 64'd0);
    tick();
    chk("dz_resp_val", 64'(bus.resp_val), 64'd1);
`else
    chk("dz_divreq", 64'(bus.divreq_val), 64'd1);
`endif
    wait_resp();
    chk("dz_data", 64'(bus.resp_data), 64'hFFFFFFFF);
    bus.resp_rdy = 1'b1;
    tick();
    bus.resp_rdy = 1'b0;
    bus.divreq_rdy = 1'b0;
    send(2'd1, 32'hFFFFFC18, 32'd7, 5'd16);
    begin
      int iss0;
      iss0 = issues;
      for (int i = 0; i < 5; i++) begin
        chk("stall_val", 64'(bus.divreq_val), 64'd1);
        chk("stall_a", 64'(bus.divreq_msg_a), 64'hFFFFFC18);
        chk("stall_b", 64'(bus.divreq_msg_b), 64'd7);
        chk("stall_fn", 64'(bus.divreq_msg_fn), 64'd1);
        tick();
      end
      chk("stall_no_issue", 64'(issues), 64'(iss0));
      bus.divreq_rdy = 1'b1;
      tick();
      chk("stall_one_issue", 64'(issues), 64'(iss0 + 1));
      chk("stall_val_drop", 64'(bus.divreq_val), 64'd0);
    end
    wait_resp();
    chk("stall_data", 64'(bus.resp_data), 64'hFFFFFF72);
    bus.resp_rdy = 1'b1;
    tick();
    bus.resp_rdy = 1'b0;
    lat = 0;
    begin
      int d0;
      d0 = done_m;
      for (int k = 0; k < 3; k++) begin
        bus.req_op = 2'd0;
        bus.req_a = 32'd1000 + 32'(k);
        bus.req_b = 32'd3;
        bus.req_tag = 5'(11 + k);
        bus.req_val = 1'b1;
        chk("full_acc", 64'(bus.req_rdy), 64'd1);
        tick();
      end
      bus.req_a = 32'd2000;
      bus.req_tag = 5'd14;
      for (int i = 0; i < 4; i++) begin
        chk("full_block", 64'(bus.req_rdy), 64'd0);
        tick();
      end
      bus.resp_rdy = 1'b1;
      for (int i = 0; i < 20 && !bus.req_rdy; i++) tick();
      chk("full_reopen", 64'(bus.req_rdy), 64'd1);
      tick();
      bus.req_val = 1'b0;
      for (int i = 0; i < 100 && (sb.size() > 0 || bus.resp_val); i++) tick();
      chk("full_drained", 64'(sb.size()), 64'd0);
      chk("full_count", 64'(done_m - d0), 64'd4);
    end
    bus.resp_rdy = 1'b0;
    lat = 8;
    send(2'd0, 32'd77, 32'd7, 5'd20);
    send(2'd2, 32'd78, 32'd7, 5'd21);
    chk("mid_wait", 64'(bus.divresp_rdy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_req_rdy", 64'(bus.req_rdy), 64'd1);
    chk("mid_resp_val", 64'(bus.resp_val), 64'd0);
    chk("mid_done", 64'(bus.done_count), 64'd0);
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("mid_quiet", 64'({bus.resp_val, bus.divreq_val}), 64'd0);
      tick();
    end
    begin
      logic [1:0] ty;
      for (int c = 0; c < 400; c++) begin
        if (!bus.req_val && $urandom_range(0, 1) == 1) begin
          bus.req_op = 2'($urandom_range(0, 3));
          bus.req_a = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
          ty = 2'($urandom_range(0, 3));
          bus.req_b = ty == 0 ? 32'd0 : ty == 1 ? 32'($urandom_range(1, 10)) : ty == 2 ? 32'hFFFFFFFF : $urandom;
          bus.req_tag = 5'($urandom_range(0, 31));
          bus.req_val = 1'b1;
        end
        bus.divreq_rdy = $urandom_range(0, 3) != 0;
        bus.resp_rdy = $urandom_range(0, 1) == 1;
        lat = $urandom_range(0, 3);
        if (bus.req_val && bus.req_rdy) begin
          tick();
          bus.req_val = 1'b0;
        end else tick();
      end
    end
    bus.req_val = 1'b0;
    bus.divreq_rdy = 1'b1;
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < 200 && (sb.size() > 0 || bus.resp_val); i++) tick();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_done", 64'(bus.done_count), 64'(16'(done_m)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imuldiv_div_issuer.md
Name: imuldiv_div_issuer

Overview:
Requester-side front end for the iterative divider's val/rdy request/response interface. It accepts tagged DIV/DIVU/REM/REMU operations into a small in-order queue and issues them one at a time on divreq. It consumes the 64-bit {remainder, quotient} divresp, selects the 32-bit quotient or remainder, and returns it with its tag on a registered response port. It sits between the pipeline's execute stage and the divider. Exactly one operation is outstanding at the divider at any time.

Parameters:
TAG_W, 5, width of the request/response tag
QUEUE_DEPTH, 2, request queue entries; power of two, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_val  in  1  upstream request valid
req_rdy  out  1  upstream request ready (queue not full)
req_op  in  2  0=DIVU 1=DIV 2=REMU 3=REM; bit0 selects signed, bit1 selects remainder
req_a  in  32  dividend
req_b  in  32  divisor
req_tag  in  TAG_W  destination tag
divreq_msg_fn  out  1  to divider: 1=signed
divreq_msg_a  out  32  to divider: dividend
divreq_msg_b  out  32  to divider: divisor
divreq_val  out  1  to divider: request valid
divreq_rdy  in  1  from divider: request ready
divresp_msg_result  in  64  from divider: {remainder[63:32], quotient[31:0]}
divresp_val  in  1  from divider: response valid
divresp_rdy  out  1  to divider: response ready
resp_val  out  1  result valid
resp_rdy  in  1  result consumed
resp_data  out  32  selected quotient or remainder
resp_tag  out  TAG_W  tag of the result
done_count  out  16  completed-operation counter

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: queue empty, state ISSUE, req_rdy=1, divreq_val=0, divresp_rdy=0, resp_val=0, resp_data=0, resp_tag=0, done_count=0.
- Queue: circular FIFO of {op, a, b, tag}, with a count register of width log2(QUEUE_DEPTH)+1.
  - req_rdy = !full.
  - Enqueue on req_val && req_rdy.
  - Enqueue and pop in the same cycle leave the count unchanged.
  - No bypass: a request enqueued at edge N can first drive divreq_val in the cycle after N.
  - Pointers wrap modulo QUEUE_DEPTH.
- divreq_msg_fn, divreq_msg_a and divreq_msg_b are driven combinationally from the queue head. They are held stable while divreq_val=1 and !divreq_rdy.
- FSM states: ISSUE, WAIT, RESP.
  - ISSUE: divreq_val = !empty. On divreq_val && divreq_rdy: pop the head, latch sel_rem=op[1] and the tag, go to WAIT. If empty, stay in ISSUE.
  - WAIT: divresp_rdy=1; divreq_val=0. On divresp_val: resp_data <= sel_rem ? result[63:32] : result[31:0]; resp_tag <= latched tag; go to RESP.
  - RESP: resp_val=1, with data and tag held stable. On resp_rdy: done_count += 1 (wraps 0xFFFF->0), go to ISSUE.
- The queue keeps accepting requests in every state. No new divreq is issued until the RESP handshake completes. Responses are returned strictly in request order.
- Minimum latency with an empty queue and a ready divider: request edge N -> divreq_val in cycle N+1 -> divider latency -> resp_val the cycle after the divresp_val cycle.
- resp_rdy is ignored outside RESP. divresp_val is ignored outside WAIT.
- Reset mid-operation (any state): the queue is flushed, any in-flight result is discarded, and no response is produced for it. The divider shares the same reset, so both ends return to idle together.

Optional Feature:
IMULDIV_DIVZERO_BYPASS_EN.
- Defined: in ISSUE, a head entry with b==0 is never sent to the divider (divreq_val=0 for it). The entry is popped and the FSM goes directly to RESP. resp_data = sel_rem ? a : 32'hFFFFFFFF, for both signed and unsigned ops; done_count increments normally.
- Undefined: b==0 is issued to the divider like any other operation, and the divider's result is passed through.

Test Plan:
- DIVU a=100 b=7 tag=3, then REMU same operands tag=4 -> resp_data=14 tag=3, then resp_data=2 tag=4; done_count=2.
- DIV a=0xFFFFFFF9 (-7) b=2, then REM same operands -> 0xFFFFFFFD (-3), then 0xFFFFFFFF (-1).
- resp_rdy=0, four back-to-back requests with QUEUE_DEPTH=2 -> requests 1-3 accepted (1 in flight, 2 queued), req_rdy=0 for request 4 until the first RESP handshake, then request 4 is accepted the next cycle; all four responses return in tag order.
- Divider holds divreq_rdy=0 for 5 cycles -> divreq_val stays 1 with a/b/fn unchanged; exactly one issue handshake occurs.
- reset pulsed for 1 cycle while in WAIT with 1 entry queued -> next cycle req_rdy=1, resp_val=0, done_count=0; no response appears for either dropped op.
- DIVU a=5 b=0 -> with macro: no divreq_val pulse, resp_val 2 cycles after the enqueue edge, data=0xFFFFFFFF; REMU a=5 b=0 -> data=5. Without macro: the op is issued to the divider and the divider's result is passed through.
